// File: rtl/vend_pkg.sv
// vend_pkg: controller state encoding, coin unit and default price/credit constants
// shared by the vending dispense controller and its gap timer.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } vend_state_e;

  localparam int COIN_UNIT      = 50;
  localparam int CW             = 3;
  localparam int TW             = 16;
  localparam int PRICE0_DEF     = 4;
  localparam int PRICE1_DEF     = 3;
  localparam int MAX_CREDIT_DEF = 6;

endpackage

// File: rtl/vend_gap_timer.sv
// vend_gap_timer: loadable down-counter with zero flag; counts down when enabled and
// holds at zero. Shared by motor timeout, change pacing and optional idle refund.
module vend_gap_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: coin credit, product arbitration, timed motor dispense and paced change.
// Define VEND_IDLE_TIMEOUT_EN to auto-refund credit left idle for IDLE_TO cycles.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int PRICE0     = PRICE0_DEF,
  parameter int PRICE1     = PRICE1_DEF,
  parameter int MTR_TO     = 1000,
  parameter int CHG_GAP    = 8
`ifdef VEND_IDLE_TIMEOUT_EN
  , parameter int IDLE_TO  = 5000
`endif
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_coin50,
  input  logic          i_coin100,
  input  logic [1:0]    i_sel,
  input  logic          i_cancel,
  input  logic [1:0]    i_stock_empty,
  input  logic          i_mtr_done,
  output logic [CW-1:0] o_credit,
  output logic [1:0]    o_mtr_on,
  output logic          o_coin_out,
  output logic          o_coin_rej,
  output logic          o_insuf,
  output logic          o_y,
  output logic          o_fault,
  output logic [1:0]    o_state
);

  // state    | meaning
  // IDLE     | take coins, cancel and selections
  // DISPENSE | motor on, waiting for mtr_done or timeout
  // CHANGE   | eject one coin every CHG_GAP cycles until credit is 0

  localparam logic [CW-1:0] L_PRICE0   = CW'(PRICE0);
  localparam logic [CW-1:0] L_PRICE1   = CW'(PRICE1);
  localparam logic [CW:0]   L_MAX      = (CW+1)'(MAX_CREDIT);
  localparam logic [TW-1:0] L_MTR_LOAD = TW'(MTR_TO - 1);
  localparam logic [TW-1:0] L_GAP_LOAD = TW'(CHG_GAP - 1);

  vend_state_e   r_state, w_state_nx;
  logic [CW-1:0] r_credit, w_credit_nx;
  logic [1:0]    r_mtr_on, w_mtr_on_nx;
  logic          r_fault, w_fault_nx;
  logic          r_coin_out, r_coin_rej, r_insuf, r_y;
  logic          w_coin_out_nx, w_coin_rej_nx, w_insuf_nx, w_y_nx;
  logic          w_taken, w_tmr_load, w_tmr_en, w_tmr_zero;
  logic [TW-1:0] w_tmr_val;
  logic [CW-1:0] w_coin_val, w_price;
  logic [CW:0]   w_sum;
`ifdef VEND_IDLE_TIMEOUT_EN
  localparam logic [TW-1:0] L_IDLE_LOAD = TW'(IDLE_TO - 1);
  logic w_any_pulse;
  assign w_any_pulse = i_coin50 | i_coin100 | i_cancel | (|i_sel);
`endif

  assign w_coin_val = i_coin100 ? CW'(2) : CW'(1);
  assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_price    = r_mtr_on[1] ? L_PRICE1 : L_PRICE0;

  vend_gap_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_credit_nx   = r_credit;
    w_mtr_on_nx   = r_mtr_on;
    w_fault_nx    = r_fault;
    w_coin_out_nx = 1'b0;
    w_coin_rej_nx = 1'b0;
    w_insuf_nx    = 1'b0;
    w_y_nx        = 1'b0;
    w_taken       = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_tmr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cancel && (r_credit != '0)) begin
          w_taken    = 1'b1;
          w_state_nx = ST_CHANGE;
          w_tmr_load = 1'b1;
        end else if (i_sel[0]) begin
          if ((r_credit >= L_PRICE0) && !i_stock_empty[0] && !r_fault) begin
            w_taken     = 1'b1;
            w_state_nx  = ST_DISPENSE;
            w_mtr_on_nx = 2'b01;
            w_credit_nx = r_credit - L_PRICE0;
            w_tmr_load  = 1'b1;
            w_tmr_val   = L_MTR_LOAD;
          end else begin
            w_insuf_nx = 1'b1;
          end
        end else if (i_sel[1]) begin
          if ((r_credit >= L_PRICE1) && !i_stock_empty[1] && !r_fault) begin
            w_taken     = 1'b1;
            w_state_nx  = ST_DISPENSE;
            w_mtr_on_nx = 2'b10;
            w_credit_nx = r_credit - L_PRICE1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = L_MTR_LOAD;
          end else begin
            w_insuf_nx = 1'b1;
          end
        end
`ifdef VEND_IDLE_TIMEOUT_EN
        // Any user pulse or empty credit restarts the idle window.
        if (!w_taken) begin
          if (w_any_pulse || (r_credit == '0)) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = L_IDLE_LOAD;
          end else if (w_tmr_zero) begin
            w_taken    = 1'b1;
            w_state_nx = ST_CHANGE;
            w_tmr_load = 1'b1;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
`endif
      end
      ST_DISPENSE: begin
        if (i_mtr_done) begin
          w_mtr_on_nx = 2'b00;
          w_y_nx      = 1'b1;
          w_state_nx  = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
          w_tmr_load  = 1'b1;
        end else if (w_tmr_zero) begin
          w_mtr_on_nx = 2'b00;
          w_fault_nx  = 1'b1;
          w_credit_nx = r_credit + w_price;
          w_state_nx  = ST_CHANGE;
          w_tmr_load  = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_CHANGE: begin
        if (r_credit == '0) begin
          w_state_nx = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_coin_out_nx = 1'b1;
          w_credit_nx   = r_credit - CW'(1);
          w_tmr_load    = 1'b1;
          w_tmr_val     = L_GAP_LOAD;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // coin100 wins a simultaneous pair; the coin50 always bounces.
    if (i_coin50 || i_coin100) begin
      if ((r_state == ST_IDLE) && !w_taken && !r_fault && (w_sum <= L_MAX)) begin
        w_credit_nx = r_credit + w_coin_val;
      end else begin
        w_coin_rej_nx = 1'b1;
      end
      if (i_coin50 && i_coin100) begin
        w_coin_rej_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_mtr_on   <= 2'b00;
      r_fault    <= 1'b0;
      r_coin_out <= 1'b0;
      r_coin_rej <= 1'b0;
      r_insuf    <= 1'b0;
      r_y        <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_credit   <= w_credit_nx;
      r_mtr_on   <= w_mtr_on_nx;
      r_fault    <= w_fault_nx;
      r_coin_out <= w_coin_out_nx;
      r_coin_rej <= w_coin_rej_nx;
      r_insuf    <= w_insuf_nx;
      r_y        <= w_y_nx;
    end
  end

  assign o_credit   = r_credit;
  assign o_mtr_on   = r_mtr_on;
  assign o_coin_out = r_coin_out;
  assign o_coin_rej = r_coin_rej;
  assign o_insuf    = r_insuf;
  assign o_y        = r_y;
  assign o_fault    = r_fault;
  assign o_state    = r_state;

endmodule
